// File: rtl/ctrl_pipe_chain.sv
// Control-word carrier for ID/EX, EX/MEM, MEM/WB plus load-use stall, branch flush and EX forwarding selects.
// ex_/mem_/wb_ fields lag capture by 1/2/3 cycles; stall/flush/fwd are combinational; no backpressure beyond the one-bubble stall.
module ctrl_pipe_chain (
  input  logic       clk,
  input  logic       rst,
  input  logic       id_valid,
  input  logic       id_RegDst,
  input  logic       id_ALUSrc,
  input  logic       id_MemtoReg,
  input  logic       id_RegWrite,
  input  logic       id_MemRead,
  input  logic       id_MemWrite,
  input  logic       id_Branch,
  input  logic       id_Jump,
  input  logic       id_BEQ_OR_BNE,
  input  logic [1:0] id_ALUOp,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic [4:0] id_rd,
  input  logic       ex_zero,
  output logic       stall,
  output logic       flush,
  output logic       ex_ALUSrc,
  output logic [1:0] ex_ALUOp,
  output logic [4:0] ex_rs,
  output logic [4:0] ex_rt,
  output logic [1:0] fwd_a,
  output logic [1:0] fwd_b,
  output logic       mem_MemRead,
  output logic       mem_MemWrite,
  output logic       mem_RegWrite,
  output logic [4:0] mem_wreg,
  output logic       wb_RegWrite,
  output logic       wb_MemtoReg,
  output logic [4:0] wb_wreg
);

  typedef struct packed {
    logic       reg_write;
    logic       mem_to_reg;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic       jump;
    logic       bne;
    logic       alu_src;
    logic [1:0] alu_op;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] wreg;
  } idex_t;

  typedef struct packed {
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       mem_to_reg;
    logic [4:0] wreg;
  } exmem_t;

  typedef struct packed {
    logic       reg_write;
    logic       mem_to_reg;
    logic [4:0] wreg;
  } memwb_t;

  idex_t  idex_q,  idex_d;
  exmem_t exmem_q, exmem_d;
  memwb_t memwb_q, memwb_d;

  logic taken;
  logic uses_rt;
  logic load_hit;
  logic bubble;

  always_comb begin
    taken    = idex_q.jump | (idex_q.branch & (ex_zero ^ idex_q.bne));
    uses_rt  = ~id_ALUSrc | id_MemWrite;
    load_hit = idex_q.mem_read & (idex_q.wreg != 5'd0) &
               ((idex_q.wreg == id_rs) | (uses_rt & (idex_q.wreg == id_rt)));
    flush    = taken;
    stall    = load_hit & id_valid & ~taken;
    // With id_valid=0 this is a constant 1, so X control inputs never reach idex_d.
    bubble   = ~id_valid | stall | taken;
  end

  always_comb begin
    idex_d = '0;
    if (!bubble) begin
      idex_d.reg_write  = id_RegWrite;
      idex_d.mem_to_reg = id_MemtoReg;
      idex_d.mem_read   = id_MemRead;
      idex_d.mem_write  = id_MemWrite;
      idex_d.branch     = id_Branch;
      idex_d.jump       = id_Jump;
      idex_d.bne        = id_BEQ_OR_BNE;
      idex_d.alu_src    = id_ALUSrc;
      idex_d.alu_op     = id_ALUOp;
      idex_d.rs         = id_rs;
      idex_d.rt         = id_rt;
      idex_d.wreg       = id_RegDst ? id_rd : id_rt;
    end
  end

  always_comb begin
    exmem_d.mem_read   = idex_q.mem_read;
    exmem_d.mem_write  = idex_q.mem_write;
    exmem_d.reg_write  = idex_q.reg_write;
    exmem_d.mem_to_reg = idex_q.mem_to_reg;
    exmem_d.wreg       = idex_q.wreg;
    memwb_d.reg_write  = exmem_q.reg_write;
    memwb_d.mem_to_reg = exmem_q.mem_to_reg;
    memwb_d.wreg       = exmem_q.wreg;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idex_q  <= '0;
      exmem_q <= '0;
      memwb_q <= '0;
    end else begin
      idex_q  <= idex_d;
      exmem_q <= exmem_d;
      memwb_q <= memwb_d;
    end
  end

  // EX/MEM is the younger producer, so it outranks MEM/WB.
  function automatic logic [1:0] fwd_sel(input logic [4:0] src);
    if (exmem_q.reg_write && exmem_q.wreg != 5'd0 && exmem_q.wreg == src)
      return 2'b10;
    else if (memwb_q.reg_write && memwb_q.wreg != 5'd0 && memwb_q.wreg == src)
      return 2'b01;
    else
      return 2'b00;
  endfunction

  always_comb begin
    fwd_a = fwd_sel(idex_q.rs);
    fwd_b = fwd_sel(idex_q.rt);
  end

  assign ex_ALUSrc    = idex_q.alu_src;
  assign ex_ALUOp     = idex_q.alu_op;
  assign ex_rs        = idex_q.rs;
  assign ex_rt        = idex_q.rt;
  assign mem_MemRead  = exmem_q.mem_read;
  assign mem_MemWrite = exmem_q.mem_write;
  assign mem_RegWrite = exmem_q.reg_write;
  assign mem_wreg     = exmem_q.wreg;
  assign wb_RegWrite  = memwb_q.reg_write;
  assign wb_MemtoReg  = memwb_q.mem_to_reg;
  assign wb_wreg      = memwb_q.wreg;

endmodule

// File: tb/tb_ctrl_pipe_chain.sv
// Bench for ctrl_pipe_chain: directed scenarios with literal expectations plus a randomized run against a history model.
module tb_ctrl_pipe_chain;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid, id_RegDst, id_ALUSrc, id_MemtoReg, id_RegWrite;
  logic       id_MemRead, id_MemWrite, id_Branch, id_Jump, id_BEQ_OR_BNE;
  logic [1:0] id_ALUOp;
  logic [4:0] id_rs, id_rt, id_rd;
  logic       ex_zero;
  logic       stall, flush, ex_ALUSrc;
  logic [1:0] ex_ALUOp, fwd_a, fwd_b;
  logic [4:0] ex_rs, ex_rt, mem_wreg, wb_wreg;
  logic       mem_MemRead, mem_MemWrite, mem_RegWrite, wb_RegWrite, wb_MemtoReg;

  ctrl_pipe_chain dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_RegDst(id_RegDst), .id_ALUSrc(id_ALUSrc),
    .id_MemtoReg(id_MemtoReg), .id_RegWrite(id_RegWrite), .id_MemRead(id_MemRead),
    .id_MemWrite(id_MemWrite), .id_Branch(id_Branch), .id_Jump(id_Jump),
    .id_BEQ_OR_BNE(id_BEQ_OR_BNE), .id_ALUOp(id_ALUOp), .id_rs(id_rs), .id_rt(id_rt),
    .id_rd(id_rd), .ex_zero(ex_zero), .stall(stall), .flush(flush), .ex_ALUSrc(ex_ALUSrc),
    .ex_ALUOp(ex_ALUOp), .ex_rs(ex_rs), .ex_rt(ex_rt), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .mem_MemRead(mem_MemRead), .mem_MemWrite(mem_MemWrite), .mem_RegWrite(mem_RegWrite),
    .mem_wreg(mem_wreg), .wb_RegWrite(wb_RegWrite), .wb_MemtoReg(wb_MemtoReg), .wb_wreg(wb_wreg)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  typedef struct packed {
    logic v, regdst, alusrc, memtoreg, regwrite, memread, memwrite, branch, jump, bne;
    logic [1:0] aluop;
    logic [4:0] rs, rt, rd;
  } ins_t;

  localparam ins_t NOP = '0;

  function automatic ins_t mk_add(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
    ins_t w = '0;
    w.v = 1; w.regdst = 1; w.regwrite = 1; w.memtoreg = 1; w.aluop = 2'b10;
    w.rs = rs; w.rt = rt; w.rd = rd;
    return w;
  endfunction

  function automatic ins_t mk_lw(input logic [4:0] rs, input logic [4:0] rt);
    ins_t w = '0;
    w.v = 1; w.alusrc = 1; w.regwrite = 1; w.memread = 1; w.rs = rs; w.rt = rt;
    return w;
  endfunction

  function automatic ins_t mk_ori(input logic [4:0] rs, input logic [4:0] rt);
    ins_t w = '0;
    w.v = 1; w.alusrc = 1; w.regwrite = 1; w.memtoreg = 1; w.aluop = 2'b11; w.rs = rs; w.rt = rt;
    return w;
  endfunction

  function automatic ins_t mk_br(input logic bne, input logic [4:0] rs, input logic [4:0] rt);
    ins_t w = '0;
    w.v = 1; w.branch = 1; w.bne = bne; w.aluop = 2'b01; w.rs = rs; w.rt = rt;
    return w;
  endfunction

  function automatic ins_t mk_j();
    ins_t w = '0;
    w.v = 1; w.jump = 1;
    return w;
  endfunction

  task automatic drive(input ins_t w);
    id_valid = w.v; id_RegDst = w.regdst; id_ALUSrc = w.alusrc; id_MemtoReg = w.memtoreg;
    id_RegWrite = w.regwrite; id_MemRead = w.memread; id_MemWrite = w.memwrite;
    id_Branch = w.branch; id_Jump = w.jump; id_BEQ_OR_BNE = w.bne; id_ALUOp = w.aluop;
    id_rs = w.rs; id_rt = w.rt; id_rd = w.rd;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      drive(NOP);
      ex_zero = 1'b0;
    end
  endtask

  // Model: what sits in EX, MEM, WB is simply the last three captured words.
  typedef struct packed {
    logic rw, mtr, mr, mw, br, j, bne, asrc;
    logic [1:0] aop;
    logic [4:0] rs, rt, wreg;
  } ctrl_t;

  ctrl_t h [3];
  bit    started = 0;

  function automatic logic [1:0] fsel(input logic [4:0] r, input ctrl_t m, input ctrl_t w);
    if (r != 0 && m.rw && m.wreg == r) return 2'b10;
    if (r != 0 && w.rw && w.wreg == r) return 2'b01;
    return 2'b00;
  endfunction

  always @(negedge clk) begin
    ctrl_t ex, mm, wb, cap;
    logic  tk, st;
    ex = h[0]; mm = h[1]; wb = h[2];
    tk = ex.j || (ex.br && (ex_zero != ex.bne));
    st = id_valid && !tk && ex.mr && ex.wreg != 0 &&
         (ex.wreg == id_rs || ((!id_ALUSrc || id_MemWrite) && ex.wreg == id_rt));
    if (started && !rst) begin
      chk("model_comb", {stall, flush, fwd_a, fwd_b},
          {st, tk, fsel(ex.rs, mm, wb), fsel(ex.rt, mm, wb)});
      chk("model_regs",
          {ex_ALUSrc, ex_ALUOp, ex_rs, ex_rt, mem_MemRead, mem_MemWrite, mem_RegWrite, mem_wreg,
           wb_RegWrite, wb_MemtoReg, wb_wreg},
          {ex.asrc, ex.aop, ex.rs, ex.rt, mm.mr, mm.mw, mm.rw, mm.wreg, wb.rw, wb.mtr, wb.wreg});
    end
    if (rst) begin
      h[0] = '0; h[1] = '0; h[2] = '0;
      started = 1;
    end else begin
      cap = '0;
      if (id_valid && !st && !tk) begin
        cap.rw = id_RegWrite; cap.mtr = id_MemtoReg; cap.mr = id_MemRead; cap.mw = id_MemWrite;
        cap.br = id_Branch; cap.j = id_Jump; cap.bne = id_BEQ_OR_BNE; cap.asrc = id_ALUSrc;
        cap.aop = id_ALUOp; cap.rs = id_rs; cap.rt = id_rt;
        cap.wreg = id_RegDst ? id_rd : id_rt;
      end
      h[2] = h[1]; h[1] = h[0]; h[0] = cap;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    ins_t w;
    w = 'x;
    rst = 1'b1;
    drive(w);
    ex_zero = 1'bx;
    repeat (3) tick();
    rst = 1'b0;
    w.v = 1'b0;
    drive(w);
    ex_zero = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("reset_zero", {stall, flush, ex_ALUSrc, ex_ALUOp, ex_rs, ex_rt, fwd_a, fwd_b, mem_MemRead,
          mem_MemWrite, mem_RegWrite, mem_wreg, wb_RegWrite, wb_MemtoReg, wb_wreg}, 64'd0);
      chk("reset_no_x", {63'd0, $isunknown({stall, flush, ex_ALUSrc, ex_ALUOp, ex_rs, ex_rt, fwd_a,
          fwd_b, mem_MemRead, mem_MemWrite, mem_RegWrite, mem_wreg, wb_RegWrite, wb_MemtoReg,
          wb_wreg})}, 64'd0);
      tick();
    end

    // R-format walk-through
    drive(mk_add(5'd1, 5'd2, 5'd3));
    tick(); drive(NOP);
    @(negedge clk); chk("rfmt_ex_aluop", ex_ALUOp, 2'b10);
    tick();
    @(negedge clk); chk("rfmt_mem", {mem_RegWrite, mem_wreg}, {1'b1, 5'd3});
    tick();
    @(negedge clk); chk("rfmt_wb", {wb_RegWrite, wb_MemtoReg, wb_wreg}, {1'b1, 1'b1, 5'd3});

    // Load-use
    idle(3);
    tick(); drive(mk_lw(5'd1, 5'd5));
    tick(); drive(mk_add(5'd5, 5'd2, 5'd6));
    @(negedge clk); chk("lu_stall", stall, 1'b1);
    tick(); drive(mk_add(5'd5, 5'd2, 5'd6));
    @(negedge clk); chk("lu_stall_once", stall, 1'b0);
    chk("lu_bubble", {ex_rs, ex_ALUOp, ex_ALUSrc}, 8'd0);
    tick(); drive(NOP);
    @(negedge clk); chk("lu_fwd", {ex_rs, fwd_a, fwd_b}, {5'd5, 2'b01, 2'b00});

    // Forwarding priority, then the same pattern on register 0
    idle(3);
    tick(); drive(mk_ori(5'd0, 5'd7));
    tick(); drive(mk_ori(5'd0, 5'd7));
    tick(); drive(mk_add(5'd7, 5'd7, 5'd8));
    tick(); drive(NOP);
    @(negedge clk); chk("fwd_prio", {fwd_a, fwd_b}, {2'b10, 2'b10});
    idle(3);
    tick(); drive(mk_ori(5'd0, 5'd0));
    tick(); drive(mk_ori(5'd0, 5'd0));
    tick(); drive(mk_add(5'd0, 5'd0, 5'd8));
    tick(); drive(NOP);
    @(negedge clk); chk("fwd_r0", {fwd_a, fwd_b}, 4'b0000);

    // Branches
    idle(3);
    tick(); drive(mk_br(1'b1, 5'd1, 5'd2));
    tick(); drive(mk_add(5'd1, 5'd2, 5'd4)); ex_zero = 1'b0;
    @(negedge clk); chk("bne_taken", flush, 1'b1);
    tick(); drive(NOP);
    @(negedge clk); chk("bne_bubble", {flush, ex_rs, ex_ALUOp}, 8'd0);
    tick(); drive(mk_br(1'b0, 5'd1, 5'd2));
    tick(); drive(NOP); ex_zero = 1'b0;
    @(negedge clk); chk("beq_not_taken", flush, 1'b0);
    tick(); drive(mk_br(1'b0, 5'd1, 5'd2));
    tick(); drive(NOP); ex_zero = 1'b1;
    @(negedge clk); chk("beq_taken", flush, 1'b1);
    tick(); drive(mk_j()); ex_zero = 1'b0;
    tick(); drive(NOP); ex_zero = 1'bx;
    @(negedge clk); chk("j_taken", flush, 1'b1);
    tick(); ex_zero = 1'b0;
    drive(mk_lw(5'd1, 5'd5));
    tick(); drive(mk_br(1'b0, 5'd5, 5'd3));
    @(negedge clk); chk("lw_beq_stall", stall, 1'b1);
    idle(3);
    w = mk_br(1'b0, 5'd1, 5'd5);
    w.memread = 1'b1;
    tick(); drive(w);
    tick(); drive(mk_add(5'd5, 5'd2, 5'd6)); ex_zero = 1'b1;
    @(negedge clk); chk("flush_over_stall", {flush, stall}, 2'b10);

    // Reset mid-stream
    idle(3);
    tick(); drive(mk_add(5'd1, 5'd2, 5'd3));
    tick(); drive(mk_ori(5'd0, 5'd4));
    tick(); drive(mk_lw(5'd1, 5'd5));
    tick(); drive(NOP);
    @(negedge clk); chk("pre_reset_busy", {mem_RegWrite, wb_RegWrite}, 2'b11);
    rst = 1'b1;
    tick(); rst = 1'b0;
    @(negedge clk);
    chk("midreset_zero", {ex_ALUSrc, ex_ALUOp, ex_rs, ex_rt, mem_MemRead, mem_MemWrite, mem_RegWrite,
        mem_wreg, wb_RegWrite, wb_MemtoReg, wb_wreg}, 64'd0);

    // Randomized run against the model
    for (int i = 0; i < 600; i++) begin
      tick();
      rst = ($urandom_range(0, 63) == 0);
      w = ins_t'({$urandom, $urandom});
      w.v  = ($urandom_range(0, 3) != 0);
      w.rs = 5'($urandom_range(0, 7));
      w.rt = 5'($urandom_range(0, 7));
      w.rd = 5'($urandom_range(0, 7));
      drive(w);
      ex_zero = 1'($urandom);
    end
    tick(); rst = 1'b0; drive(NOP);
    idle(2);
    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ctrl_pipe_chain.md
# ctrl_pipe_chain

Carries the decoded control word from the ID stage through the ID/EX, EX/MEM and MEM/WB registers of the 5-stage MIPS pipeline. It is the consumer side of the opcode decoder. It also generates the pipeline-management signals derived from that control word:

- load-use stall
- branch/jump resolution and flush
- EX-stage forwarding selects

Datapath registers (operands, ALU results) live elsewhere; this block owns only control and destination-register fields.

## Interface
Parameters: none.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- id_valid  in  1  ID holds a real instruction; 0 = treat the control word as a bubble
- id_RegDst, id_ALUSrc, id_MemtoReg, id_RegWrite, id_MemRead, id_MemWrite, id_Branch, id_Jump, id_BEQ_OR_BNE  in  1 each  decoder outputs; may be X
- id_ALUOp  in  2  decoder ALU op
- id_rs, id_rt, id_rd  in  5 each  instruction register fields
- ex_zero  in  1  ALU zero flag for the instruction currently in EX
- stall  out  1  hold PC and IF/ID this cycle (combinational)
- flush  out  1  clear IF/ID; redirect PC to branch/jump target (combinational)
- ex_ALUSrc  out  1, ex_ALUOp  out  2  EX controls
- ex_rs, ex_rt  out  5 each  registered source fields
- fwd_a, fwd_b  out  2 each  ALU operand selects: 00 = register file, 10 = EX/MEM result, 01 = MEM/WB result
- mem_MemRead, mem_MemWrite, mem_RegWrite  out  1 each; mem_wreg  out  5
- wb_RegWrite, wb_MemtoReg  out  1 each; wb_wreg  out  5  (wb_MemtoReg: 1 = ALU result, 0 = memory data)

## Operation
- **ID/EX capture.** ID/EX captures the ID control word, id_rs and id_rt, and wreg.
  - wreg = id_RegDst ? id_rd : id_rt.
  - ALUOp is carried unchanged; 11 = ORI.
- **Bubble.** A bubble is loaded instead of the ID word when id_valid=0, stall=1 or flush=1. A bubble is an all-zero control word with wreg=0, rs=0, rt=0.
- **X sanitising.** Any X control input with id_valid=0 must never reach a register. Registered control bits are always 0/1.
- **Downstream copies.**
  - EX/MEM ← ID/EX: MemRead, MemWrite, RegWrite, MemtoReg, wreg.
  - MEM/WB ← EX/MEM: RegWrite, MemtoReg, wreg.
- **Load-use stall.** stall = ex_MemRead & ex_wreg≠0 & (ex_wreg==id_rs | (uses_rt & ex_wreg==id_rt)) & id_valid & ~flush.
  - uses_rt = ~id_ALUSrc | id_MemWrite.
  - The rt check is conservative for J; this is accepted.
- **Branch resolution in EX.** taken = ex_Jump | (ex_Branch & (ex_zero ^ ex_BEQ_OR_BNE)).
  - BEQ_OR_BNE = 0 → BEQ, 1 → BNE.
  - flush = taken.
- **Flush vs. stall.** Flush has priority over stall: stall is forced to 0 when flush=1.
- **Forwarding for ex_rs (fwd_a).** fwd_a = 10 if mem_RegWrite & mem_wreg≠0 & mem_wreg==ex_rs; else 01 if wb_RegWrite & wb_wreg≠0 & wb_wreg==ex_rs; else 00.
- **Forwarding for ex_rt (fwd_b).** fwd_b uses the same rule with ex_rt.
- **Register 0.** Never forwarded, never stalls.

## Timing
- **Reset.** rst=1 at a clock edge zeroes all ID/EX, EX/MEM and MEM/WB fields. Consequently stall=0, flush=0, fwd_a=fwd_b=00, and all ex_/mem_/wb_ outputs are 0 the cycle after.
  - Reset mid-stream discards all in-flight instructions.
  - rst has priority over stall/flush.
- **Latency.** An ID word appears at ex_* 1 cycle, mem_* 2 cycles and wb_* 3 cycles after capture.
- **Stall.** A stall inserts exactly one bubble. The held instruction is re-presented by the fetch side and captured next cycle, when ex_MemRead=0.
- **Flush.** flush is asserted in the same cycle the branch/jump is in EX. The ID word in that cycle is replaced by a bubble. The instruction already in IF/ID is cleared by the fetch side, so a taken branch costs 2 bubbles.
- **Combinational outputs.** stall, flush, fwd_a and fwd_b depend only on current register contents and ID inputs; they have no registered delay.
- **No hold.** EX/MEM and MEM/WB advance every cycle.

## Test plan
- **Reset.** Reset with X on all id_* inputs, then release with id_valid=0 for 4 cycles → all outputs 0, no X on any output.
- **R-format walk-through.** add rd=3 (RegDst=1, RegWrite=1, MemtoReg=1, ALUOp=10), id_valid=1 → ex_ALUOp=10 at +1; mem_RegWrite=1, mem_wreg=3 at +2; wb_RegWrite=1, wb_MemtoReg=1, wb_wreg=3 at +3.
- **Load-use.** LW rt=5, followed by add rs=5 → stall=1 for exactly one cycle. ex_* is a bubble the next cycle; then the add is captured with fwd_a=01 in its EX cycle.
- **Forwarding priority.** ori rt=7, ori rt=7, add rs=7 rt=7 → fwd_a=fwd_b=10 in the add's EX cycle, because MEM/WB also matches and EX/MEM wins. With wreg=0 in the same sequence → fwd=00.
- **Branches.**
  - BNE with ex_zero=0 → flush=1, next ex_* is a bubble.
  - BEQ with ex_zero=0 → flush=0.
  - J with ex_zero=x → flush=1.
  - LW then BEQ taken in the same cycle as a load-use match → flush=1, stall=0.
- **Reset mid-stream.** rst pulse with 3 instructions in flight → every mem_/wb_ output is 0 on the following cycle.
